// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared types, widths and the single-cycle ALU function for alu_exec
//
// Contents:
//   REG_WIDTH / REG_ADDRW  register file geometry
//   op_t                   ALU opcode encodings (ALU_MUL included; other codes are illegal)
//   sel_t                  right-operand source: register or immediate
//   state_t                execution FSM states
//   FLAG_*                 bit positions inside the packed flag vector
//   alu_single()           result/flags for every op except ALU_MUL
package alu_exec_pkg;

    localparam int REG_WIDTH = 64;
    localparam int REG_ADDRW = 4;
    localparam int SHAMT_W   = $clog2(REG_WIDTH);

    typedef logic [REG_WIDTH-1:0] word_t;
    typedef logic [REG_ADDRW-1:0] raddr_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_SAR = 4'd7,
        ALU_MUL = 4'd8
    } op_t;

    typedef enum logic {
        SEL_REG = 1'b0,
        SEL_IMM = 1'b1
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_B = 3'd1,
        ST_RD_A = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_O    = 2;
    localparam int FLAG_S    = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    typedef struct packed {
        logic   legal;
        word_t  result;
        flags_t flags;
    } alu_res_t;

    // B is the left operand, A the right one. ALU_MUL and unknown codes
    // come back with legal=0; the multiplier path is handled by the caller.
    function automatic alu_res_t alu_single(op_t op, word_t b, word_t a);
        alu_res_t             r;
        logic [REG_WIDTH:0]   ext;
        logic [SHAMT_W-1:0]   sh;
        r     = '0;
        r.legal = 1'b1;
        ext   = '0;
        sh    = a[SHAMT_W-1:0];
        case (op)
            ALU_ADD: begin
                ext            = {1'b0, b} + {1'b0, a};
                r.result       = ext[REG_WIDTH-1:0];
                r.flags[FLAG_C] = ext[REG_WIDTH];
                // Same-sign operands producing an opposite-sign sum overflow.
                r.flags[FLAG_O] = (b[REG_WIDTH-1] == a[REG_WIDTH-1]) &&
                                  (r.result[REG_WIDTH-1] != b[REG_WIDTH-1]);
            end
            ALU_SUB: begin
                // The 65th bit of the zero-extended difference is the borrow.
                ext            = {1'b0, b} - {1'b0, a};
                r.result       = ext[REG_WIDTH-1:0];
                r.flags[FLAG_C] = ext[REG_WIDTH];
                r.flags[FLAG_O] = (b[REG_WIDTH-1] != a[REG_WIDTH-1]) &&
                                  (r.result[REG_WIDTH-1] != b[REG_WIDTH-1]);
            end
            ALU_AND: r.result = b & a;
            ALU_OR:  r.result = b | a;
            ALU_XOR: r.result = b ^ a;
            ALU_SHL: r.result = b << sh;
            ALU_SHR: r.result = b >> sh;
            ALU_SAR: r.result = word_t'($signed(b) >>> sh);
            default: r.legal  = 1'b0;
        endcase
        r.flags[FLAG_Z] = (r.result == '0);
        r.flags[FLAG_S] = r.result[REG_WIDTH-1];
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - decoded ALU instruction bundle between decoder (client) and alu_exec (server)
//
// Signals:
//   op      ALU operation
//   a_sel   right operand from register a_reg (SEL_REG) or from a_imm (SEL_IMM)
//   s_reg   destination register
//   b_reg   left operand register
//   a_reg   right operand register (register form)
//   a_imm   right operand immediate (immediate form)
interface if_instr_alu;
    import alu_exec_pkg::*;

    op_t    op;
    sel_t   a_sel;
    raddr_t s_reg;
    raddr_t b_reg;
    raddr_t a_reg;
    word_t  a_imm;

    modport server (input op, a_sel, s_reg, b_reg, a_reg, a_imm);
    modport client (output op, a_sel, s_reg, b_reg, a_reg, a_imm);
endinterface

// File: rtl/alu_exec_mul_seq.sv
// rtl/alu_exec_mul_seq.sv - iterative shift-add multiplier, one partial product per cycle
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i              begin a multiplication with mcand_i/mplier_i (ignored while busy_o)
//   mcand_i, mplier_i    operands, sampled in the start cycle
//   busy_o               iterations after the start cycle are in progress
//   done_o               high in the last of WIDTH cycles; product_o is valid then
//   product_o            low WIDTH bits of mcand_i * mplier_i
//
// The start cycle performs the first iteration straight from the inputs, so a
// multiplication occupies exactly WIDTH cycles including the start cycle and
// the final partial sum is presented combinationally alongside done_o.
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;

    logic             active;
    logic [CNT_W-1:0] cnt_c;
    logic [WIDTH-1:0] acc_c, mcand_c, mplier_c;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        active = start_i || run_q;
        if (run_q) begin
            cnt_c    = cnt_q;
            acc_c    = acc_q;
            mcand_c  = mcand_q;
            mplier_c = mplier_q;
        end else begin
            cnt_c    = '0;
            acc_c    = '0;
            mcand_c  = mcand_i;
            mplier_c = mplier_i;
        end
        acc_d = acc_c + (mplier_c[0] ? mcand_c : '0);
    end

    assign busy_o    = run_q;
    assign done_o    = active && (cnt_c == LAST);
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (active) begin
            run_q    <= !done_o;
            cnt_q    <= cnt_c + 1'b1;
            acc_q    <= acc_d;
            mcand_q  <= mcand_c << 1;
            mplier_q <= mplier_c >> 1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - ALU instruction executor: %s <- %b op %a / %s <- %b op imm
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   instr                            decoded instruction (server side), sampled on accept
//   start / busy / done              request; busy from cycle after accept through done;
//                                    done pulses in the write-back cycle
//   rf_rd_addr / rf_rd_data          registered read port, data one cycle after address
//   rf_wr_en/rf_wr_addr/rf_wr_data   write port, enabled only in write-back
//   zf, cf, of, sf                   flags of the last completed legal instruction
//
// Parameter MUL_EN: 1 instantiates alu_mul_seq, 0 treats ALU_MUL as illegal.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    if_instr_alu.server  instr,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output raddr_t       rf_rd_addr,
    input  word_t        rf_rd_data,
    output logic         rf_wr_en,
    output raddr_t       rf_wr_addr,
    output word_t        rf_wr_data,
    output logic         zf,
    output logic         cf,
    output logic         of,
    output logic         sf
);
    state_t state_q, state_d;
    op_t    op_q, op_d;
    sel_t   sel_q, sel_d;
    raddr_t s_q, s_d;
    raddr_t ar_q, ar_d;
    word_t  a_q, a_d;
    word_t  b_q, b_d;
    raddr_t rd_addr_q, rd_addr_d;
    raddr_t wr_addr_q, wr_addr_d;
    word_t  wr_data_q, wr_data_d;
    logic   wr_ok_q, wr_ok_d;
    flags_t flags_q, flags_d;

    alu_res_t alu_r;
    logic     ex_fin;
    logic     ex_legal;
    word_t    ex_res;
    flags_t   ex_flags;

    logic     mul_start;
    logic     mul_busy;
    logic     mul_done;
    word_t    mul_product;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(
                .WIDTH (REG_WIDTH)
            ) u_mul (
                .clk       (clk),
                .rst_n     (rst_n),
                .start_i   (mul_start),
                .mcand_i   (b_q),
                .mplier_i  (a_q),
                .busy_o    (mul_busy),
                .done_o    (mul_done),
                .product_o (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_d     = sel_q;
        s_d       = s_q;
        ar_d      = ar_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ok_d   = wr_ok_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        ex_fin    = 1'b0;
        ex_legal  = 1'b0;
        ex_res    = '0;
        ex_flags  = '0;
        alu_r     = alu_single(op_q, b_q, a_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = instr.op;
                    sel_d     = instr.a_sel;
                    s_d       = instr.s_reg;
                    ar_d      = instr.a_reg;
                    // Immediate parked in A now; RD_A overwrites it in register form.
                    a_d       = instr.a_imm;
                    rd_addr_d = instr.b_reg;
                    state_d   = ST_RD_B;
                end
            end
            ST_RD_B: begin
                b_d = rf_rd_data;
                if (sel_q == SEL_REG) begin
                    rd_addr_d = ar_q;
                    state_d   = ST_RD_A;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_RD_A: begin
                a_d     = rf_rd_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (MUL_EN && (op_q == ALU_MUL)) begin
                    // Kick the multiplier on the first EXEC cycle only.
                    mul_start = !mul_busy;
                    if (mul_done) begin
                        ex_fin           = 1'b1;
                        ex_legal         = 1'b1;
                        ex_res           = mul_product;
                        ex_flags[FLAG_Z] = (mul_product == '0);
                        ex_flags[FLAG_S] = mul_product[REG_WIDTH-1];
                    end
                end else begin
                    ex_fin   = 1'b1;
                    ex_legal = alu_r.legal;
                    ex_res   = alu_r.result;
                    ex_flags = alu_r.flags;
                end
                if (ex_fin) begin
                    wr_addr_d = s_q;
                    wr_data_d = ex_res;
                    wr_ok_d   = ex_legal && (s_q != '0);
                    if (ex_legal) begin
                        flags_d = ex_flags;
                    end
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= ALU_ADD;
            sel_q     <= SEL_REG;
            s_q       <= '0;
            ar_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ok_q   <= 1'b0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            s_q       <= s_d;
            ar_q      <= ar_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_ok_q   <= wr_ok_d;
            flags_q   <= flags_d;
        end
    end

    // The read address is issued combinationally so the registered register
    // file returns data in the very next state; otherwise it holds.
    assign rf_rd_addr = rst_n ? rd_addr_d : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_WB);
    assign rf_wr_en   = done && wr_ok_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign zf         = flags_q[FLAG_Z];
    assign cf         = flags_q[FLAG_C];
    assign of         = flags_q[FLAG_O];
    assign sf         = flags_q[FLAG_S];

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec with a register file and reference model
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int W     = REG_WIDTH;
    localparam int NREGS = 2 ** REG_ADDRW;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   busy, done, rf_wr_en, zf, cf, of, sf;
    raddr_t rf_rd_addr, rf_wr_addr;
    word_t  rf_rd_data, rf_wr_data;

    always #5 clk = ~clk;

    if_instr_alu instr ();

    alu_exec #(
        .MUL_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .zf         (zf),
        .cf         (cf),
        .of         (of),
        .sf         (sf)
    );

    // Register file attached to the DUT; %0 always reads zero.
    word_t  rf [NREGS];
    logic   poke_en = 1'b0;
    raddr_t poke_addr = '0;
    word_t  poke_data = '0;

    always @(posedge clk) begin
        rf_rd_data <= (rf_rd_addr == '0) ? '0 : rf[rf_rd_addr];
        if (poke_en) rf[poke_addr] <= poke_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        raddr_t     addr;
        word_t      data;
        logic [3:0] flags;   // {zf, cf, of, sf}
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    word_t      mdl [NREGS];
    logic [3:0] mflags = 4'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got 1, expected 0", name);
    endtask

    // Reference semantics written from the instruction definitions.
    function automatic void ref_exec(input logic [3:0] op, input word_t b, input word_t a,
                                     output logic legal, output word_t res,
                                     output logic c, output logic o);
        logic signed [W:0] ws;
        int sh;
        legal = 1'b1;
        c     = 1'b0;
        o     = 1'b0;
        res   = '0;
        ws    = '0;
        sh    = int'(a[5:0]);
        case (op)
            4'd0: begin
                res = b + a;
                c   = ({1'b0, b} + {1'b0, a}) > {1'b0, {W{1'b1}}};
                ws  = $signed({b[W-1], b}) + $signed({a[W-1], a});
                o   = (ws != $signed({res[W-1], res}));
            end
            4'd1: begin
                res = b - a;
                c   = (b < a);
                ws  = $signed({b[W-1], b}) - $signed({a[W-1], a});
                o   = (ws != $signed({res[W-1], res}));
            end
            4'd2: res = b & a;
            4'd3: res = b | a;
            4'd4: res = b ^ a;
            4'd5: res = b << sh;
            4'd6: res = b >> sh;
            4'd7: res = $signed(b) >>> sh;
            4'd8: res = b * a;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic scramble();
        instr.op    = op_t'($urandom_range(0, 15));
        instr.a_sel = sel_t'($urandom_range(0, 1));
        instr.s_reg = raddr_t'($urandom_range(0, NREGS - 1));
        instr.b_reg = raddr_t'($urandom_range(0, NREGS - 1));
        instr.a_reg = raddr_t'($urandom_range(0, NREGS - 1));
        instr.a_imm = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) fail_event("idle_timeout");
    endtask

    task automatic poke(input raddr_t a, input word_t d);
        wait_idle();
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        mdl[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic sel, input raddr_t s,
                         input raddr_t b, input raddr_t ar, input word_t imm, output int acc);
        exp_t  e;
        word_t bv, av, res;
        logic  legal, c, o;
        acc = -1;
        wait_idle();
        if (busy) return;
        bv = (b == '0) ? '0 : mdl[b];
        av = sel ? imm : ((ar == '0) ? '0 : mdl[ar]);
        ref_exec(op, bv, av, legal, res, c, o);
        if (legal) mflags = {res == '0, c, o, res[W-1]};
        e.wr    = legal && (s != '0);
        e.addr  = s;
        e.data  = res;
        e.flags = mflags;
        e.lat   = (sel ? 3 : 4) + ((op == 4'd8) ? W - 1 : 0);
        if (e.wr) mdl[s] = res;
        instr.op = op_t'(op); instr.a_sel = sel_t'(sel);
        instr.s_reg = s; instr.b_reg = b; instr.a_reg = ar; instr.a_imm = imm;
        start = 1'b1;
        @(posedge clk); #1;
        e.acc = cyc;
        acc = cyc;
        sb_q.push_back(e);
        start = 1'b0;
        scramble();
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (rf_wr_en && !done) fail_event("wr_en_outside_wb");
            if (done) begin
                if (sb_q.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_en", rf_wr_en, e.wr);
                    if (e.wr) begin
                        chk("wr_addr", rf_wr_addr, e.addr);
                        chk("wr_data", rf_wr_data, e.data);
                    end
                    chk("flags_zcos", {zf, cf, of, sf}, e.flags);
                    chk("latency", cyc - e.acc + 1, e.lat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, k, n;
        logic [3:0] op;
        word_t v;
        instr.op = ALU_ADD; instr.a_sel = SEL_REG; instr.s_reg = '0;
        instr.b_reg = '0; instr.a_reg = '0; instr.a_imm = '0;
        for (int i = 0; i < NREGS; i++) begin
            rf[i] = '0;
            mdl[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_rd_addr", rf_rd_addr, 0);
        chk("rst_wr_addr", rf_wr_addr, 0);
        chk("rst_wr_data", rf_wr_data, 0);
        chk("rst_flags", {zf, cf, of, sf}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // REG ADD wrapping to zero.
        poke(1, 64'hFFFF_FFFF_FFFF_FFFF);
        poke(2, 64'd1);
        issue(4'd0, 1'b0, 3, 1, 2, '0, a0);
        // IMM SUB with borrow.
        poke(1, 64'd5);
        issue(4'd1, 1'b1, 4, 1, 0, 64'd7, a0);
        // SAR to %0: no write, flags still produced.
        poke(1, 64'h8000_0000_0000_0000);
        issue(4'd7, 1'b1, 0, 1, 0, 64'd63, a0);
        // REG MUL with start pulses while busy.
        poke(1, 64'd12345);
        poke(2, 64'd678);
        issue(4'd8, 1'b0, 5, 1, 2, '0, a0);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1; scramble();
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
        end
        wait_idle();
        chk("mul_result_reg5", mdl[5], 64'd8369910);

        // Back-to-back: second instruction reads the first one's result.
        poke(1, {$urandom, $urandom});
        poke(2, {$urandom, $urandom});
        issue(4'd0, 1'b0, 6, 1, 2, '0, a0);
        issue(4'd1, 1'b0, 7, 6, 2, '0, a1);
        chk("b2b_spacing", a1 - a0, 5);

        // Illegal encoding: flags unchanged, no write.
        issue(4'd13, 1'b0, 9, 1, 2, '0, a0);

        // Reset in the middle of a MUL, with non-zero flags beforehand.
        issue(4'd1, 1'b1, 0, 0, 0, 64'd1, a0);
        issue(4'd8, 1'b0, 10, 1, 2, '0, a0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_wr_en", rf_wr_en, 0);
        sb_q.delete();
        mflags = 4'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("postrst_flags", {zf, cf, of, sf}, 0);
        chk("postrst_busy", busy, 0);
        repeat (80) @(posedge clk);
        #1;

        // Randomised traffic.
        for (int r = 1; r < NREGS; r++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: v = '0;
                1: v = '1;
                2: v = 64'h8000_0000_0000_0000;
                3: v = 64'h7FFF_FFFF_FFFF_FFFF;
                default: v = {$urandom, $urandom};
            endcase
            poke(raddr_t'(r), v);
        end
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 11);
            op = (k <= 8) ? 4'(k) : 4'($urandom_range(9, 15));
            v  = ($urandom_range(0, 2) == 0) ? word_t'($urandom_range(0, 70)) : {$urandom, $urandom};
            issue(op, 1'($urandom_range(0, 1)), raddr_t'($urandom_range(0, NREGS - 1)),
                  raddr_t'($urandom_range(0, NREGS - 1)), raddr_t'($urandom_range(0, NREGS - 1)),
                  v, a0);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Server end of the ALU instruction interface: accepts one decoded ALU instruction per start pulse and executes %s <- %b op %a (register form) or %s <- %b op imm (immediate form). Operands are read through a single registered read port of the register file, the result is written back, and status flags are updated. Sits between the instruction decoder (interface client) and the register file in the ULM datapath.

## Interface
- MUL_EN, 1: 1 instantiates the iterative multiplier; 0 treats ALU_MUL as illegal (no write, flags unchanged, done still pulses).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  if_instr_alu.server  -  op, a_sel, s_reg, b_reg, a_imm, a_reg; sampled only on accept.
- start  in  1  request to execute instr; accepted when start && !busy.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  single-cycle pulse in the write-back cycle.
- rf_rd_addr  out  REG_ADDRW  register file read address; data returns next cycle.
- rf_rd_data  in  REG_WIDTH  read data for the address presented in the previous cycle.
- rf_wr_en, rf_wr_addr, rf_wr_data  out  1 / REG_ADDRW / REG_WIDTH  write port.
- zf, cf, of, sf  out  1 each  registered flags of the last completed instruction.

## Operation
- FSM states: IDLE, RD_B, RD_A, EXEC, WB.
- IDLE: on accept, latch all instr fields, drive rf_rd_addr=b_reg, go RD_B.
- RD_B: capture rf_rd_data as B. REG: drive rf_rd_addr=a_reg, go RD_A. IMM: A=a_imm, go EXEC.
- RD_A: capture rf_rd_data as A, go EXEC.
- EXEC: single-cycle ops compute result, go WB. ALU_MUL starts multiplier, stays until mul_done.
- WB: rf_wr_en=1 unless s_reg==0; rf_wr_addr=s_reg; flags update; done=1; go IDLE.
- Ops (B left, A right): ADD B+A; SUB B-A; AND; OR; XOR; SHL B<<A[5:0]; SHR logical; SAR arithmetic; MUL low REG_WIDTH bits of B*A.
- Flags: zf = result==0; sf = result MSB; ADD cf = carry-out, of = signed overflow; SUB cf = borrow (B<A unsigned), of = signed overflow; all other ops cf=of=0.
- Writes to %0 suppressed; flags and done still produced.
- start while busy ignored; instr changes after accept have no effect.
- Illegal op encoding: behaves like illegal MUL (no write, flags unchanged).

## Timing
- Reset: state IDLE, busy=0, done=0, rf_wr_en=0, rf_rd_addr=0, rf_wr_addr=0, rf_wr_data=0, all flags 0.
- Accept at cycle 0. REG single-cycle op: done at cycle 4. IMM: done at cycle 3. MUL: EXEC lasts REG_WIDTH cycles, done at cycle 3+REG_WIDTH (REG) / 2+REG_WIDTH (IMM).
- Next accept possible in the cycle after done (back-to-back throughput: one instruction per 5 cycles REG).
- rf_rd_addr holds its last value outside RD_B/RD_A issue cycles; rf_wr_en is high only in WB.
- rst_n asserted mid-instruction: immediate return to reset state, no write-back, multiplier cleared.

## Structure
- pkg_alu: op_t encodings incl. ALU_MUL, sel_t, new state_t for the FSM, flag bit indices.
- pkg_reg: REG_WIDTH, REG_ADDRW (unchanged).
- Sub-module alu_mul_seq: shift-add multiplier, start/done handshake, REG_WIDTH iterations, async active-low reset.

## Test plan
- Reset mid-MUL -> no rf_wr_en pulse, busy=0, flags 0 after release.
- REG ADD, %1=0xFFFF_FFFF_FFFF_FFFF, %2=1, s=%3 -> %3=0, zf=1, cf=1, of=0, done at cycle 4.
- IMM SUB, %1=5, imm=7, s=%4 -> %4=0xFFFF_FFFF_FFFF_FFFE, cf=1, sf=1, done at cycle 3.
- SAR %1=0x8000_0000_0000_0000 by imm 63, s=%0 -> no write, sf=1, zf=0, done pulses.
- REG MUL %1=12345, %2=678 -> 8369910 written, done at cycle 3+REG_WIDTH; start pulses during busy ignored.
- Back-to-back ADD then SUB using the first result as %b -> second instruction reads the updated value.
